// File: rtl/cfu_types.sv
// Purpose: shared CFU request/response field widths and packed bus types.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cfu_types;

    localparam int C_M_CFU_REQ_ID_W   = 4;
    localparam int C_M_CFU_CFU_ID_W   = 2;
    localparam int C_M_CFU_STATE_ID_W = 2;
    localparam int C_M_CFU_FUNC_ID_W  = 10;
    localparam int C_M_CFU_INSN_W     = 32;
    localparam int C_M_CFU_DATA_W     = 32;
    localparam int C_M_CFU_STATUS_W   = 3;

    typedef struct packed {
        logic                          cfu_csr;
        logic [C_M_CFU_REQ_ID_W-1:0]   id;
        logic [C_M_CFU_CFU_ID_W-1:0]   cfu;
        logic [C_M_CFU_STATE_ID_W-1:0] state;
        logic [C_M_CFU_FUNC_ID_W-1:0]  func;
        logic [C_M_CFU_INSN_W-1:0]     insn;
        logic [C_M_CFU_DATA_W-1:0]     data0;
        logic [C_M_CFU_DATA_W-1:0]     data1;
    } cfu_req_t;

    typedef struct packed {
        logic [C_M_CFU_REQ_ID_W-1:0]   id;
        logic [C_M_CFU_STATUS_W-1:0]   status;
        logic [C_M_CFU_DATA_W-1:0]     data;
    } cfu_resp_t;

    localparam int CFU_REQ_W  = $bits(cfu_req_t);
    localparam int CFU_RESP_W = $bits(cfu_resp_t);

endpackage

// File: rtl/cfu_fifo.sv
// Purpose: registered synchronous FIFO, valid/ready on both sides, no bypass.
// Latency: an entry pushed in cycle N is visible at the pop side in cycle N+1.
// Backpressure: push_rdy = !full; a push into a full FIFO waits even if a pop happens.
//
// Ports:
//   clk, rst                       clock, async active-high reset (pointers only)
//   push_vld/push_rdy/push_dat     write side
//   pop_vld/pop_rdy/pop_dat        read side, pop_dat is the registered head entry
module cfu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    output logic             push_rdy,
    input  logic [WIDTH-1:0] push_dat,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [AW-1:0]    wr_idx, rd_idx;
    logic             wr_wrap, rd_wrap;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             full, empty, do_push, do_pop;

    // Index equality with differing wrap bits means the writer has lapped the reader.
    assign empty    = (wr_idx == rd_idx) && (wr_wrap == rd_wrap);
    assign full     = (wr_idx == rd_idx) && (wr_wrap != rd_wrap);
    assign push_rdy = !full;
    assign pop_vld  = !empty;
    assign pop_dat  = mem[rd_idx];
    assign do_push  = push_vld && !full;
    assign do_pop   = pop_rdy && !empty;

    // Explicit wrap at DEPTH-1 keeps the pointers correct for any depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx  <= '0;
            wr_wrap <= 1'b0;
            rd_idx  <= '0;
            rd_wrap <= 1'b0;
        end else begin
            if (do_push) begin
                if (wr_idx == LAST) begin
                    wr_idx  <= '0;
                    wr_wrap <= ~wr_wrap;
                end else begin
                    wr_idx <= wr_idx + AW'(1);
                end
            end
            if (do_pop) begin
                if (rd_idx == LAST) begin
                    rd_idx  <= '0;
                    rd_wrap <= ~rd_wrap;
                end else begin
                    rd_idx <= rd_idx + AW'(1);
                end
            end
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= push_dat;
        end
    end

endmodule

// File: rtl/cfu_req_queue.sv
// Purpose: decouples the CPU CFU master from the VFU CFU slave with request/response FIFOs.
// Latency: one cycle each way (accept in N, earliest presentation in N+1), no bypass.
// Backpressure: CPU stalls when the request FIFO is full or MAX_OUTSTANDING are in flight.
//
// Ports:
//   clk, rst                                  clock, async active-high reset
//   s_req_en/s_req_valid/s_req_ready/s_req    CPU request side
//   s_resp_valid/s_resp_ready/s_resp          CPU response side
//   m_req_en/m_req_valid/m_req_ready/m_req    VFU request side
//   m_resp_valid/m_resp_ready/m_resp          VFU response side
//   outstanding                               requests accepted but not yet answered to CPU
//   order_err                                 sticky: VFU response id out of order or unexpected
module cfu_req_queue
    import cfu_types::*;
#(
    parameter int REQ_DEPTH       = 4,
    parameter int RESP_DEPTH      = 4,
    // Keep <= RESP_DEPTH so every in-flight response always has a slot.
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 s_req_en,
    input  logic                                 s_req_valid,
    output logic                                 s_req_ready,
    input  cfu_req_t                             s_req,
    output logic                                 s_resp_valid,
    input  logic                                 s_resp_ready,
    output cfu_resp_t                            s_resp,
    output logic                                 m_req_en,
    output logic                                 m_req_valid,
    input  logic                                 m_req_ready,
    output cfu_req_t                             m_req,
    input  logic                                 m_resp_valid,
    output logic                                 m_resp_ready,
    input  cfu_resp_t                            m_resp,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                                 order_err
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTSTANDING);

    logic                        req_push_rdy;
    logic                        id_push_rdy;
    logic                        req_acc;
    logic                        resp_acc;
    logic                        id_vld;
    logic [C_M_CFU_REQ_ID_W-1:0] id_head;
    logic                        inc, dec;

    // Enable is a level, not a transaction: it bypasses the queue.
    assign m_req_en = s_req_en;

    // The ID tracker is never full while outstanding < MAX_OUTSTANDING in legal use;
    // including it only keeps the tracker consistent after spurious responses.
    assign s_req_ready = req_push_rdy && id_push_rdy && (outstanding < MAX_O);
    assign req_acc     = s_req_valid && s_req_ready;
    assign resp_acc    = m_resp_valid && m_resp_ready;

    cfu_fifo #(.WIDTH(CFU_REQ_W), .DEPTH(REQ_DEPTH)) u_req_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (req_acc),
        .push_rdy (req_push_rdy),
        .push_dat (s_req),
        .pop_vld  (m_req_valid),
        .pop_rdy  (m_req_ready),
        .pop_dat  (m_req)
    );

    cfu_fifo #(.WIDTH(CFU_RESP_W), .DEPTH(RESP_DEPTH)) u_resp_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (m_resp_valid),
        .push_rdy (m_resp_ready),
        .push_dat (m_resp),
        .pop_vld  (s_resp_valid),
        .pop_rdy  (s_resp_ready),
        .pop_dat  (s_resp)
    );

    // Holds the ids of requests still awaiting a VFU response, oldest at the head.
    cfu_fifo #(.WIDTH(C_M_CFU_REQ_ID_W), .DEPTH(MAX_OUTSTANDING)) u_id_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (req_acc),
        .push_rdy (id_push_rdy),
        .push_dat (s_req.id),
        .pop_vld  (id_vld),
        .pop_rdy  (resp_acc),
        .pop_dat  (id_head)
    );

    // A response with nothing expected, or with the wrong id, is flagged but still forwarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            order_err <= 1'b0;
        end else if (resp_acc && (!id_vld || (id_head != m_resp.id))) begin
            order_err <= 1'b1;
        end
    end

    // Decrement is suppressed at zero so spurious responses cannot underflow the count.
    assign inc = req_acc;
    assign dec = s_resp_valid && s_resp_ready && (outstanding != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else if (inc && !dec) begin
            outstanding <= outstanding + OW'(1);
        end else if (dec && !inc) begin
            outstanding <= outstanding - OW'(1);
        end
    end

endmodule

// File: tb/tb_cfu_req_queue.sv
// Purpose: self-checking bench for cfu_req_queue against a queue-based behavioural model.
// Latency: model queues update on the clock edge; outputs compared on the falling edge.
// Backpressure: bench drives random and directed stall patterns on both sides.
module tb_cfu_req_queue;
    import cfu_types::*;

    localparam int REQ_DEPTH  = 4;
    localparam int RESP_DEPTH = 4;
    localparam int MAX_OUT    = 4;
    localparam int OW         = $clog2(MAX_OUT + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            s_req_en = 1'b0;
    logic            s_req_valid = 1'b0;
    logic            s_req_ready;
    cfu_req_t        s_req = '0;
    logic            s_resp_valid;
    logic            s_resp_ready = 1'b0;
    cfu_resp_t       s_resp;
    logic            m_req_en;
    logic            m_req_valid;
    logic            m_req_ready = 1'b0;
    cfu_req_t        m_req;
    logic            m_resp_valid = 1'b0;
    logic            m_resp_ready;
    cfu_resp_t       m_resp = '0;
    logic [OW-1:0]   outstanding;
    logic            order_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    cfu_req_t  req_q[$];
    cfu_resp_t resp_q[$];
    logic [C_M_CFU_REQ_ID_W-1:0] id_q[$];
    cfu_req_t  vfu_pending[$];
    int        m_outst;
    bit        m_err;

    always #5 clk = ~clk;

    cfu_req_queue #(
        .REQ_DEPTH       (REQ_DEPTH),
        .RESP_DEPTH      (RESP_DEPTH),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_req_en     (s_req_en),
        .s_req_valid  (s_req_valid),
        .s_req_ready  (s_req_ready),
        .s_req        (s_req),
        .s_resp_valid (s_resp_valid),
        .s_resp_ready (s_resp_ready),
        .s_resp       (s_resp),
        .m_req_en     (m_req_en),
        .m_req_valid  (m_req_valid),
        .m_req_ready  (m_req_ready),
        .m_req        (m_req),
        .m_resp_valid (m_resp_valid),
        .m_resp_ready (m_resp_ready),
        .m_resp       (m_resp),
        .outstanding  (outstanding),
        .order_err    (order_err)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic cfu_req_t mk_req(input logic [3:0] id, input logic [31:0] d0, input logic [31:0] d1);
        cfu_req_t r;
        r.cfu_csr = 1'($urandom);
        r.id      = id;
        r.cfu     = 2'($urandom);
        r.state   = 2'($urandom);
        r.func    = 10'($urandom);
        r.insn    = $urandom;
        r.data0   = d0;
        r.data1   = d1;
        return r;
    endfunction

    function automatic cfu_resp_t mk_resp(input logic [3:0] id, input logic [31:0] d);
        cfu_resp_t r;
        r.id     = id;
        r.status = 3'($urandom);
        r.data   = d;
        return r;
    endfunction

    task automatic model_reset();
        req_q.delete();
        resp_q.delete();
        id_q.delete();
        vfu_pending.delete();
        m_outst = 0;
        m_err   = 1'b0;
    endtask

    // Applies one clock edge of handshakes to the model, all decided from pre-edge state.
    task automatic model_step();
        bit req_acc, mreq_hs, mresp_acc, sresp_hs;
        req_acc   = s_req_valid && (req_q.size() < REQ_DEPTH) && (m_outst < MAX_OUT);
        mreq_hs   = m_req_ready && (req_q.size() > 0);
        mresp_acc = m_resp_valid && (resp_q.size() < RESP_DEPTH);
        sresp_hs  = s_resp_ready && (resp_q.size() > 0);
        if (mreq_hs) begin
            vfu_pending.push_back(req_q[0]);
            void'(req_q.pop_front());
        end
        if (mresp_acc) begin
            if (id_q.size() == 0 || id_q[0] != m_resp.id) m_err = 1'b1;
            if (id_q.size() > 0) void'(id_q.pop_front());
            if (vfu_pending.size() > 0) void'(vfu_pending.pop_front());
        end
        if (req_acc) begin
            req_q.push_back(s_req);
            id_q.push_back(s_req.id);
        end
        if (sresp_hs) void'(resp_q.pop_front());
        if (mresp_acc) resp_q.push_back(m_resp);
        if (req_acc) m_outst++;
        if (sresp_hs && m_outst > 0) m_outst--;
    endtask

    task automatic check_all();
        chk("s_req_ready", 128'(s_req_ready), 128'((req_q.size() < REQ_DEPTH) && (m_outst < MAX_OUT)));
        chk("m_req_valid", 128'(m_req_valid), 128'(req_q.size() > 0));
        if (req_q.size() > 0) chk("m_req", 128'(m_req), 128'(req_q[0]));
        chk("s_resp_valid", 128'(s_resp_valid), 128'(resp_q.size() > 0));
        if (resp_q.size() > 0) chk("s_resp", 128'(s_resp), 128'(resp_q[0]));
        chk("m_resp_ready", 128'(m_resp_ready), 128'(resp_q.size() < RESP_DEPTH));
        chk("outstanding", 128'(outstanding), 128'(m_outst));
        chk("order_err", 128'(order_err), 128'(m_err));
        chk("m_req_en", 128'(m_req_en), 128'(s_req_en));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive_idle();
        s_req_valid  = 1'b0;
        m_resp_valid = 1'b0;
        m_req_ready  = 1'b1;
        s_resp_ready = 1'b1;
    endtask

    // VFU answers in order whatever it has received; CPU takes all responses.
    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            drive_idle();
            if (vfu_pending.size() > 0) begin
                m_resp_valid = 1'b1;
                m_resp = mk_resp(vfu_pending[0].id, $urandom);
            end
            cycle();
        end
        drive_idle();
    endtask

    initial begin
        logic [3:0] next_id;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_all();
        chk("rst s_req_ready", 128'(s_req_ready), 128'(1));
        chk("rst m_req_valid", 128'(m_req_valid), 128'(0));
        chk("rst m_resp_ready", 128'(m_resp_ready), 128'(1));
        chk("rst outstanding", 128'(outstanding), 128'(0));

        // Single request round trip
        drive_idle();
        s_req_en = 1'b1;
        s_req = mk_req(4'd3, 32'h11, 32'h22);
        s_req_valid = 1'b1;
        cycle();
        chk("A m_req_valid", 128'(m_req_valid), 128'(1));
        chk("A m_req.id", 128'(m_req.id), 128'(3));
        chk("A m_req.data0", 128'(m_req.data0), 128'(32'h11));
        chk("A m_req.data1", 128'(m_req.data1), 128'(32'h22));
        chk("A outstanding 1", 128'(outstanding), 128'(1));
        s_req_valid = 1'b0;
        cycle();
        m_resp_valid = 1'b1;
        m_resp = mk_resp(4'd3, 32'h33);
        s_resp_ready = 1'b0;
        cycle();
        m_resp_valid = 1'b0;
        chk("A s_resp.id", 128'(s_resp.id), 128'(3));
        chk("A s_resp.data", 128'(s_resp.data), 128'(32'h33));
        s_resp_ready = 1'b1;
        cycle();
        chk("A outstanding 0", 128'(outstanding), 128'(0));

        // VFU stalled, six requests offered
        m_req_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_req = mk_req(4'(i), $urandom, $urandom);
            s_req_valid = 1'b1;
            cycle();
        end
        s_req_valid = 1'b0;
        chk("B outstanding", 128'(outstanding), 128'(4));
        chk("B s_req_ready", 128'(s_req_ready), 128'(0));
        chk("B m_req.id", 128'(m_req.id), 128'(0));
        m_req_ready  = 1'b1;
        s_resp_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_resp_valid = 1'b0;
            if (vfu_pending.size() > 0) begin
                chk("B m_resp_ready", 128'(m_resp_ready), 128'(1));
                m_resp_valid = 1'b1;
                m_resp = mk_resp(vfu_pending[0].id, $urandom);
            end
            cycle();
        end
        m_resp_valid = 1'b0;
        chk("B s_resp held id", 128'(s_resp.id), 128'(0));
        drain(6);
        chk("B outstanding 0", 128'(outstanding), 128'(0));

        // Same-cycle CPU response and new request at outstanding=2
        s_resp_ready = 1'b0;
        for (int i = 4; i < 6; i++) begin
            s_req = mk_req(4'(i), $urandom, $urandom);
            s_req_valid = 1'b1;
            cycle();
        end
        s_req_valid  = 1'b0;
        m_resp_valid = 1'b1;
        m_resp = mk_resp(vfu_pending[0].id, $urandom);
        cycle();
        m_resp_valid = 1'b0;
        chk("C outstanding pre", 128'(outstanding), 128'(2));
        s_req = mk_req(4'd6, $urandom, $urandom);
        s_req_valid  = 1'b1;
        s_resp_ready = 1'b1;
        cycle();
        chk("C outstanding same", 128'(outstanding), 128'(2));
        drain(12);

        // VFU answers out of order
        s_req = mk_req(4'd1, $urandom, $urandom);
        s_req_valid = 1'b1;
        cycle();
        s_req = mk_req(4'd2, $urandom, $urandom);
        cycle();
        s_req_valid = 1'b0;
        cycle();
        m_resp_valid = 1'b1;
        m_resp = mk_resp(4'd2, 32'haa);
        cycle();
        chk("D order_err set", 128'(order_err), 128'(1));
        m_resp = mk_resp(4'd1, 32'hbb);
        cycle();
        m_resp_valid = 1'b0;
        vfu_pending.delete();
        drain(4);
        chk("D order_err sticky", 128'(order_err), 128'(1));
        chk("D outstanding", 128'(outstanding), 128'(0));

        // Asynchronous reset with two requests queued
        m_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_req = mk_req(4'(i), $urandom, $urandom);
            s_req_valid = 1'b1;
            cycle();
        end
        s_req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("E m_req_valid", 128'(m_req_valid), 128'(0));
        chk("E s_req_ready", 128'(s_req_ready), 128'(1));
        chk("E outstanding", 128'(outstanding), 128'(0));
        chk("E order_err", 128'(order_err), 128'(0));
        chk("E s_resp_valid", 128'(s_resp_valid), 128'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        check_all();
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("E no m_req after rst", 128'(m_req_valid), 128'(0));
        end

        // Spurious VFU response with nothing outstanding
        s_resp_ready = 1'b0;
        m_resp_valid = 1'b1;
        m_resp = mk_resp(4'd9, 32'h55);
        cycle();
        m_resp_valid = 1'b0;
        chk("F order_err", 128'(order_err), 128'(1));
        chk("F s_resp.id", 128'(s_resp.id), 128'(9));
        s_resp_ready = 1'b1;
        cycle();
        chk("F outstanding", 128'(outstanding), 128'(0));

        // Randomized traffic, restarting from reset to clear the sticky flag
        rst = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        next_id = 4'd0;
        for (int i = 0; i < 3000; i++) begin
            s_req_en    = 1'($urandom);
            s_req_valid = ($urandom_range(0, 2) != 0);
            s_req       = mk_req(next_id, $urandom, $urandom);
            next_id     = next_id + 4'd1;
            m_req_ready  = ($urandom_range(0, 3) != 0);
            s_resp_ready = ($urandom_range(0, 2) != 0);
            m_resp_valid = 1'b0;
            if (vfu_pending.size() > 0 && $urandom_range(0, 1) == 1) begin
                m_resp_valid = 1'b1;
                m_resp = mk_resp(vfu_pending[0].id, $urandom);
                if (i > 2500 && $urandom_range(0, 39) == 0) m_resp.id = m_resp.id ^ 4'd1;
            end
            cycle();
        end
        drain(20);
        chk("R outstanding drained", 128'(outstanding), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
